// File: rtl/bread_pkg.sv
// Shared types and helpers for the programmable bread machine controller:
// phase encodings, duration-to-cycle conversion and default durations.
package bread_pkg;

   // Phase encoding shown on the front panel; values are fixed.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_KNEAD = 3'd1,
      ST_RISE  = 3'd2,
      ST_BAKE  = 3'd3,
      ST_RING  = 3'd4,
      ST_WARM  = 3'd5
   } state_e;

   localparam int PHASE_W = 3;

   // Default programme, in seconds, and default clock rate in Hz.
   localparam int unsigned DEF_FREQ         = 1;
   localparam int unsigned DEF_KNEAD_S      = 900;
   localparam int unsigned DEF_RISE_S       = 7200;
   localparam int unsigned DEF_RISE_RAPID_S = 3600;
   localparam int unsigned DEF_BAKE_S       = 1500;
   localparam int unsigned DEF_BELL_S       = 10;
   localparam int unsigned DEF_WARM_S       = 1800;
   localparam int          DEF_TIMER_W      = 16;

   // Cycle counts for the default programme at the default clock rate.
   localparam longint unsigned DEF_KNEAD_CYC = 64'(DEF_KNEAD_S) * 64'(DEF_FREQ);
   localparam longint unsigned DEF_BAKE_CYC  = 64'(DEF_BAKE_S) * 64'(DEF_FREQ);

   // Converts a duration in seconds into clock cycles, in 64-bit arithmetic
   // so that the range check below sees the true product.
   function automatic longint unsigned dur_cycles(input longint unsigned secs,
                                                  input longint unsigned freq);
      return secs * freq;
   endfunction

   // A phase of D cycles loads D-1, so D may be at most 2**w and never 0.
   function automatic bit dur_ok(input longint unsigned cycles, input int unsigned w);
      return (cycles != 64'd0) && (cycles <= (64'd1 << w));
   endfunction

   // Phases in which the pause button is honoured.
   function automatic logic is_pausable(input state_e s);
      return (s == ST_KNEAD) || (s == ST_RISE) || (s == ST_BAKE);
   endfunction

endpackage

// File: rtl/bread_timer.sv
// Loadable down-counter for phase timing. Load wins over hold; the count
// stops at zero rather than wrapping.
module bread_timer #(
   parameter int TIMER_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic [TIMER_W-1:0] load_value_i,
   input  logic               hold_i,
   output logic [TIMER_W-1:0] count_o,
   output logic               elapsed_o
);

   logic [TIMER_W-1:0] count_q;
   logic [TIMER_W-1:0] count_d;

   // Next count: load, else decrement when running and non-zero, else hold.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_value_i;
      end else if (!hold_i && (count_q != '0)) begin
         count_d = count_q - TIMER_W'(1);
      end
   end

   // Count register, cleared by the asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Expiry flag and count are plain decodes of the register.
   always_comb begin
      count_o   = count_q;
      elapsed_o = (count_q == '0);
   end

endmodule

// File: rtl/bread_machine_prog.sv
// Programmable bread machine controller: knead, rise, bake, bell and an
// optional keep-warm phase, with rapid rise, pause/resume and cancel.
// All outputs are decoded from registered state; no input reaches an
// output combinationally.
module bread_machine_prog
   import bread_pkg::*;
#(
   parameter int unsigned FREQ         = DEF_FREQ,
   parameter int unsigned KNEAD_S      = DEF_KNEAD_S,
   parameter int unsigned RISE_S       = DEF_RISE_S,
   parameter int unsigned RISE_RAPID_S = DEF_RISE_RAPID_S,
   parameter int unsigned BAKE_S       = DEF_BAKE_S,
   parameter int unsigned BELL_S       = DEF_BELL_S,
   parameter int unsigned WARM_S       = DEF_WARM_S,
   parameter int          TIMER_W      = DEF_TIMER_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_button,
   input  logic               pause_button,
   input  logic               cancel_button,
   input  logic               rapid_mode,
   input  logic               keep_warm,
   output logic               bell,
   output logic               heating_element,
   output logic               paddle_motor,
   output logic               paused,
   output logic [2:0]         phase,
   output logic [TIMER_W-1:0] remaining
);

   // Phase lengths in clock cycles.
   localparam longint unsigned KNEAD_C = dur_cycles(64'(KNEAD_S), 64'(FREQ));
   localparam longint unsigned RISE_C  = dur_cycles(64'(RISE_S), 64'(FREQ));
   localparam longint unsigned RAPID_C = dur_cycles(64'(RISE_RAPID_S), 64'(FREQ));
   localparam longint unsigned BAKE_C  = dur_cycles(64'(BAKE_S), 64'(FREQ));
   localparam longint unsigned BELL_C  = dur_cycles(64'(BELL_S), 64'(FREQ));
   localparam longint unsigned WARM_C  = dur_cycles(64'(WARM_S), 64'(FREQ));

   localparam bit DUR_OK = dur_ok(KNEAD_C, TIMER_W) && dur_ok(RISE_C, TIMER_W) &&
                           dur_ok(RAPID_C, TIMER_W) && dur_ok(BAKE_C, TIMER_W) &&
                           dur_ok(BELL_C, TIMER_W)  && dur_ok(WARM_C, TIMER_W);

   // A phase of D cycles counts D-1 down to 0.
   localparam logic [TIMER_W-1:0] KNEAD_LD = TIMER_W'(KNEAD_C - 64'd1);
   localparam logic [TIMER_W-1:0] RISE_LD  = TIMER_W'(RISE_C - 64'd1);
   localparam logic [TIMER_W-1:0] RAPID_LD = TIMER_W'(RAPID_C - 64'd1);
   localparam logic [TIMER_W-1:0] BAKE_LD  = TIMER_W'(BAKE_C - 64'd1);
   localparam logic [TIMER_W-1:0] BELL_LD  = TIMER_W'(BELL_C - 64'd1);
   localparam logic [TIMER_W-1:0] WARM_LD  = TIMER_W'(WARM_C - 64'd1);

   // Refuse to build with a zero-length phase or one the timer cannot hold.
   if (!DUR_OK) begin : g_bad_duration
      $error("bread_machine_prog: a phase duration times FREQ is 0 or exceeds 2**TIMER_W");
   end

   state_e             state_q, state_d;
   logic               paused_q, paused_d;
   logic               rapid_q, rapid_d;
   logic               warm_q, warm_d;
   logic               pause_prev_q, pause_prev_d;
   logic               pause_edge;

   logic               tmr_load;
   logic [TIMER_W-1:0] tmr_load_val;
   logic               tmr_hold;
   logic [TIMER_W-1:0] tmr_count;
   logic               tmr_elapsed;

   bread_timer #(
      .TIMER_W (TIMER_W)
   ) u_timer (
      .clk          (clk),
      .rst          (rst),
      .load_i       (tmr_load),
      .load_value_i (tmr_load_val),
      .hold_i       (tmr_hold),
      .count_o      (tmr_count),
      .elapsed_o    (tmr_elapsed)
   );

   assign pause_prev_d = pause_button;
   assign pause_edge   = pause_button & ~pause_prev_q;

   // State, pause flag, latched mode bits and pause edge history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         paused_q     <= 1'b0;
         rapid_q      <= 1'b0;
         warm_q       <= 1'b0;
         pause_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         paused_q     <= paused_d;
         rapid_q      <= rapid_d;
         warm_q       <= warm_d;
         pause_prev_q <= pause_prev_d;
      end
   end

   // Next state and timer control. Priority: cancel, then pause toggle,
   // then timer expiry. The toggle cycle itself freezes the timer, so a
   // pause landing on the last cycle of a phase suppresses the transition.
   always_comb begin
      state_d      = state_q;
      paused_d     = paused_q;
      rapid_d      = rapid_q;
      warm_d       = warm_q;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      tmr_hold     = paused_q;

      if (state_q == ST_IDLE) begin
         tmr_hold = 1'b1;
         paused_d = 1'b0;
         if (start_button) begin
            rapid_d      = rapid_mode;
            warm_d       = keep_warm;
            state_d      = ST_KNEAD;
            tmr_load     = 1'b1;
            tmr_load_val = KNEAD_LD;
         end
      end else if (cancel_button) begin
         state_d      = ST_IDLE;
         paused_d     = 1'b0;
         tmr_load     = 1'b1;
         tmr_load_val = '0;
      end else if (pause_edge && is_pausable(state_q)) begin
         paused_d = ~paused_q;
         tmr_hold = 1'b1;
      end else if (!paused_q && tmr_elapsed) begin
         tmr_load = 1'b1;
         case (state_q)
            ST_KNEAD: begin
               state_d      = ST_RISE;
               tmr_load_val = rapid_q ? RAPID_LD : RISE_LD;
            end
            ST_RISE: begin
               state_d      = ST_BAKE;
               tmr_load_val = BAKE_LD;
            end
            ST_BAKE: begin
               state_d      = ST_RING;
               paused_d     = 1'b0;
               tmr_load_val = BELL_LD;
            end
            ST_RING: begin
               if (warm_q) begin
                  state_d      = ST_WARM;
                  tmr_load_val = WARM_LD;
               end else begin
                  state_d      = ST_IDLE;
                  paused_d     = 1'b0;
                  tmr_load_val = '0;
               end
            end
            ST_WARM: begin
               state_d      = ST_IDLE;
               paused_d     = 1'b0;
               tmr_load_val = '0;
            end
            default: begin
               state_d      = ST_IDLE;
               paused_d     = 1'b0;
               tmr_load_val = '0;
            end
         endcase
      end
   end

   // Moore output decode; heater and paddle drop out while paused.
   always_comb begin
      bell            = 1'b0;
      heating_element = 1'b0;
      paddle_motor    = 1'b0;
      paused          = paused_q;
      phase           = state_q;
      remaining       = tmr_count;
      case (state_q)
         ST_KNEAD: paddle_motor    = ~paused_q;
         ST_RISE:  heating_element = ~paused_q;
         ST_BAKE:  heating_element = ~paused_q;
         ST_WARM:  heating_element = ~paused_q;
         ST_RING:  bell            = 1'b1;
         default:  ;
      endcase
   end

endmodule

// File: tb/tb_bread_machine_prog.sv
// Bench for bread_machine_prog using the short test programme. A reference
// model holds the remaining programme as a queue of (phase, cycles) entries
// built at start and consumed as each phase runs out.
module tb_bread_machine_prog;

   localparam int TIMER_W = 8;
   localparam int D_KNEAD = 4;
   localparam int D_RISE  = 6;
   localparam int D_RAPID = 3;
   localparam int D_BAKE  = 5;
   localparam int D_BELL  = 2;
   localparam int D_WARM  = 3;

   logic               clk;
   logic               rst;
   logic               start_button;
   logic               pause_button;
   logic               cancel_button;
   logic               rapid_mode;
   logic               keep_warm;
   logic               bell;
   logic               heating_element;
   logic               paddle_motor;
   logic               paused;
   logic [2:0]         phase;
   logic [TIMER_W-1:0] remaining;

   int checks   = 0;
   int failures = 0;

   // Model state: current phase, cycles left in it (including this one),
   // pause flag, last pause button level and the rest of the programme.
   int          m_phase;
   int          m_left;
   bit          m_paused;
   bit          m_prev;
   logic [15:0] plan_q[$];

   bread_machine_prog #(
      .FREQ         (1),
      .KNEAD_S      (D_KNEAD),
      .RISE_S       (D_RISE),
      .RISE_RAPID_S (D_RAPID),
      .BAKE_S       (D_BAKE),
      .BELL_S       (D_BELL),
      .WARM_S       (D_WARM),
      .TIMER_W      (TIMER_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start_button    (start_button),
      .pause_button    (pause_button),
      .cancel_button   (cancel_button),
      .rapid_mode      (rapid_mode),
      .keep_warm       (keep_warm),
      .bell            (bell),
      .heating_element (heating_element),
      .paddle_motor    (paddle_motor),
      .paused          (paused),
      .phase           (phase),
      .remaining       (remaining)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase  = 0;
      m_left   = 0;
      m_paused = 1'b0;
      m_prev   = 1'b0;
      plan_q.delete();
   endtask

   task automatic next_phase();
      logic [15:0] e;
      if (plan_q.size() == 0) begin
         m_phase  = 0;
         m_left   = 0;
         m_paused = 1'b0;
      end else begin
         e        = plan_q.pop_front();
         m_phase  = int'(e[15:8]);
         m_left   = int'(e[7:0]);
         m_paused = 1'b0;
      end
   endtask

   task automatic model_step();
      bit pedge;
      pedge  = pause_button && !m_prev;
      m_prev = pause_button;
      if (m_phase == 0) begin
         if (start_button) begin
            plan_q.delete();
            plan_q.push_back({8'd1, 8'(D_KNEAD)});
            plan_q.push_back({8'd2, rapid_mode ? 8'(D_RAPID) : 8'(D_RISE)});
            plan_q.push_back({8'd3, 8'(D_BAKE)});
            plan_q.push_back({8'd4, 8'(D_BELL)});
            if (keep_warm) plan_q.push_back({8'd5, 8'(D_WARM)});
            next_phase();
         end
      end else if (cancel_button) begin
         plan_q.delete();
         next_phase();
      end else if (pedge && (m_phase >= 1) && (m_phase <= 3)) begin
         m_paused = !m_paused;
      end else if (!m_paused) begin
         m_left--;
         if (m_left == 0) next_phase();
      end
   endtask

   task automatic compare_all();
      bit heat_phase;
      heat_phase = (m_phase == 2) || (m_phase == 3) || (m_phase == 5);
      check_val("phase", 32'(phase), 32'(m_phase));
      check_val("remaining", 32'(remaining), (m_phase == 0) ? 32'd0 : 32'(m_left - 1));
      check_val("paused", 32'(paused), 32'(m_paused));
      check_val("bell", 32'(bell), 32'(m_phase == 4));
      check_val("heater", 32'(heating_element), 32'(heat_phase && !m_paused));
      check_val("paddle", 32'(paddle_motor), 32'((m_phase == 1) && !m_paused));
   endtask

   // One clock: advance the model with the inputs seen at the edge, then
   // compare shortly after the edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic reset_pulse();
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      compare_all();
      check_val("rst_bell", 32'(bell), 32'd0);
      check_val("rst_heater", 32'(heating_element), 32'd0);
      #2;
      rst = 1'b1;
   endtask

   task automatic idle_inputs();
      start_button  = 1'b0;
      pause_button  = 1'b0;
      cancel_button = 1'b0;
   endtask

   task automatic settle();
      idle_inputs();
      for (int i = 0; i < 60 && m_phase != 0; i++) tick();
      tick();
      check_val("settle_idle", 32'(m_phase), 32'd0);
   endtask

   task automatic start_cycle(input bit rapid, input bit warm);
      rapid_mode   = rapid;
      keep_warm    = warm;
      start_button = 1'b1;
      tick();
      start_button = 1'b0;
   endtask

   task automatic wait_model_phase(input int ph, input int left, input string tag);
      int n;
      n = 0;
      while (!(m_phase == ph && (left < 0 || m_left == left)) && n < 60) begin
         tick();
         n++;
      end
      if (n >= 60) check_val(tag, 32'(m_phase), 32'(ph));
   endtask

   initial begin
      int n_paddle, n_heat, n_bell, n_rise, n_warm, n;
      rst = 1'b0;
      idle_inputs();
      rapid_mode = 1'b0;
      keep_warm  = 1'b0;
      model_reset();

      // Reset state
      #12;
      compare_all();
      rst = 1'b1;
      tick();

      // Full normal cycle
      start_cycle(1'b0, 1'b0);
      check_val("knead_first_rem", 32'(remaining), 32'd3);
      n_paddle = 32'(paddle_motor);
      n_heat   = 0;
      n_bell   = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         n_paddle += int'(paddle_motor);
         n_heat   += int'(heating_element);
         n_bell   += int'(bell);
      end
      check_val("normal_paddle_cycles", 32'(n_paddle), 32'd4);
      check_val("normal_heat_cycles", 32'(n_heat), 32'd11);
      check_val("normal_bell_cycles", 32'(n_bell), 32'd2);
      check_val("normal_end_phase", 32'(phase), 32'd0);

      // Rapid rise with keep-warm; mode inputs change mid-cycle
      start_cycle(1'b1, 1'b1);
      rapid_mode = 1'b0;
      keep_warm  = 1'b0;
      n_heat = 0;
      n_rise = 0;
      n_warm = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         n_heat += int'(heating_element);
         n_rise += int'(phase == 3'd2);
         n_warm += int'(phase == 3'd5);
      end
      check_val("rapid_rise_cycles", 32'(n_rise), 32'd3);
      check_val("warm_cycles", 32'(n_warm), 32'd3);
      check_val("rapid_heat_cycles", 32'(n_heat), 32'd11);
      check_val("rapid_end_phase", 32'(phase), 32'd0);

      // Pause in BAKE at remaining 2, hold, then resume
      start_cycle(1'b0, 1'b0);
      wait_model_phase(3, 3, "reach_bake_rem2");
      pause_button = 1'b1;
      tick();
      check_val("pause_flag", 32'(paused), 32'd1);
      check_val("pause_heater", 32'(heating_element), 32'd0);
      check_val("pause_rem", 32'(remaining), 32'd2);
      for (int i = 0; i < 6; i++) tick();
      pause_button = 1'b0;
      tick();
      check_val("pause_rem_held", 32'(remaining), 32'd2);
      pause_button = 1'b1;
      tick();
      check_val("resume_flag", 32'(paused), 32'd0);
      n = 0;
      while (phase == 3'd3 && n < 20) begin
         tick();
         n++;
      end
      check_val("resume_bake_cycles", 32'(n), 32'd3);
      settle();

      // Cancel together with a pause edge during RISE
      start_cycle(1'b0, 1'b0);
      wait_model_phase(2, -1, "reach_rise");
      tick();
      cancel_button = 1'b1;
      pause_button  = 1'b1;
      tick();
      check_val("cancel_phase", 32'(phase), 32'd0);
      check_val("cancel_paused", 32'(paused), 32'd0);
      check_val("cancel_rem", 32'(remaining), 32'd0);
      check_val("cancel_heater", 32'(heating_element), 32'd0);
      settle();

      // Ignored inputs: start during KNEAD, rapid change, pause in RING
      start_cycle(1'b0, 1'b0);
      rapid_mode   = 1'b1;
      start_button = 1'b1;
      tick();
      tick();
      start_button = 1'b0;
      check_val("knead_start_ignored", 32'(phase), 32'd1);
      n_rise = 0;
      for (int i = 0; i < 40 && m_phase != 4; i++) begin
         tick();
         n_rise += int'(phase == 3'd2);
      end
      check_val("latched_rise_cycles", 32'(n_rise), 32'd6);
      pause_button = 1'b1;
      tick();
      check_val("ring_pause_ignored", 32'(paused), 32'd0);
      check_val("ring_bell", 32'(bell), 32'd1);
      settle();

      // Asynchronous reset during BAKE
      start_cycle(1'b0, 1'b1);
      wait_model_phase(3, -1, "reach_bake");
      reset_pulse();
      for (int i = 0; i < 5; i++) tick();
      check_val("post_reset_idle", 32'(phase), 32'd0);

      // Randomised operation
      for (int i = 0; i < 3000; i++) begin
         start_button  = ($urandom_range(0, 3) == 0);
         cancel_button = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 5) == 0) pause_button = ~pause_button;
         rapid_mode = 1'($urandom_range(0, 1));
         keep_warm  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 999) == 0) reset_pulse();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bread_machine_prog.md
Name: bread_machine_prog

Overview:
- Parametrised, programmable successor to the fixed-recipe bread machine controller; timer and control FSM are integrated in one block.
- Sequence: knead, rise, bake, bell, optional keep-warm.
- Adds a rapid-rise mode, pause/resume, cancel, a keep-warm phase, and status outputs for the front-panel display.
- Sits between the debounced front-panel buttons and the heater and motor drivers.

Parameters:
- FREQ, 1: clock frequency in Hz; every duration below is in seconds and multiplied by FREQ.
- KNEAD_S, 900: knead phase duration.
- RISE_S, 7200: normal rise duration.
- RISE_RAPID_S, 3600: rise duration when rapid mode is latched.
- BAKE_S, 1500: bake duration.
- BELL_S, 10: bell ring duration.
- WARM_S, 1800: keep-warm duration.
- TIMER_W, 16: timer and remaining-count width. Elaboration must fail if any duration×FREQ exceeds 2^TIMER_W or is 0.

Ports:
- clk, in, 1: clock; all state changes on the rising edge.
- rst, in, 1: asynchronous, active-low reset.
- start_button, in, 1: synchronous level; starts a cycle from IDLE.
- pause_button, in, 1: synchronous level; each rising edge toggles pause.
- cancel_button, in, 1: synchronous level; aborts the cycle.
- rapid_mode, in, 1: sampled at start; selects RISE_RAPID_S.
- keep_warm, in, 1: sampled at start; enables the WARM phase.
- bell, out, 1: high in RING.
- heating_element, out, 1: high in BAKE, and in RISE/WARM, only when not paused.
- paddle_motor, out, 1: high in KNEAD when not paused.
- paused, out, 1: pause flag.
- phase, out, 3: current state encoding.
- remaining, out, TIMER_W: current timer value, 0 in IDLE.

Behaviour:
- States and phase encoding: IDLE=0, KNEAD=1, RISE=2, BAKE=3, RING=4, WARM=5.
- Outputs are a Moore decode of registered state, the paused flag and timer; no input-to-output combinational path.
- Heating per state:
  - RISE: heater on (warm proof).
  - BAKE: heater on.
  - WARM: heater on.
  - All of the above gated off while paused.
- Reset (rst low, asynchronous): state=IDLE, timer=0, paused=0, latched mode bits=0, pause edge register=0; all outputs 0.
- Timer rule:
  - On entry to a phase with duration D = X_S×FREQ, timer loads D-1.
  - Timer decrements each cycle while not paused.
  - When timer==0 and not paused, the next edge moves to the next phase.
  - An unpaused phase therefore lasts exactly D cycles.
- IDLE: when start_button=1, latch rapid_mode and keep_warm, then go to KNEAD next edge. start_button is ignored in all other states.
- Transitions:
  - KNEAD → RISE.
  - RISE → BAKE. RISE uses RISE_RAPID_S if rapid was latched.
  - BAKE → RING.
  - RING → WARM if keep_warm was latched, else → IDLE.
  - WARM → IDLE.
- Pause:
  - A rising edge of pause_button (registered previous value) toggles paused, but only in KNEAD, RISE and BAKE.
  - Pause edges are ignored in IDLE, RING and WARM.
  - paused is forced to 0 on leaving BAKE and on any return to IDLE.
  - While paused, the timer holds and the state holds.
- Cancel: cancel_button=1 in any non-IDLE state → IDLE on the next edge, timer=0, paused=0.
- Priority within one cycle: cancel > pause toggle > timer expiry. A pause edge on the cycle timer==0 suppresses the transition; the phase resumes at 0 when unpaused.
- Timer arithmetic:
  - Unsigned, TIMER_W bits, no wrap.
  - The timer never decrements below 0 because expiry always reloads.
  - In IDLE the timer holds 0.
- Latched mode bits hold for the whole cycle; input changes mid-cycle have no effect.

Decomposition:
- Shared package bread_pkg:
  - state enum and its phase encodings (IDLE..WARM);
  - a duration-to-cycles constant function;
  - the localparam cycle counts derived from parameters.
- Sub-module bread_timer: TIMER_W loadable down-counter.
  - Inputs: load, load_value, hold.
  - Outputs: count, elapsed (count==0).
- The FSM stays in bread_machine_prog.

Test Plan (FREQ=1, KNEAD_S=4, RISE_S=6, RISE_RAPID_S=3, BAKE_S=5, BELL_S=2, WARM_S=3, TIMER_W=8):
- Full normal cycle:
  - Stimulus: rst low then high; start 1 cycle; rapid=0, keep_warm=0.
  - Required: paddle high for 4 cycles (remaining 3..0); heater high for 6 (RISE) then 5 (BAKE); bell high for 2; then phase=0 and all outputs 0.
- Rapid + warm:
  - Stimulus: start with rapid=1, keep_warm=1.
  - Required: RISE lasts 3 cycles; after RING, WARM holds heater for 3 cycles; then IDLE.
- Pause:
  - Stimulus: pause edge at BAKE remaining=2; hold 7 cycles; second edge.
  - Required: heater 0, paused=1, remaining stays 2; after resume, BAKE ends 3 cycles later.
- Cancel/priority:
  - Stimulus: cancel and pause edge together in RISE.
  - Required: next cycle phase=0, paused=0, remaining=0, all outputs 0.
- Ignored inputs:
  - Stimulus: start pulses during KNEAD; pause edge during RING; toggle rapid_mode mid-cycle.
  - Required: no state change; latched rapid value used.
- Async reset:
  - Stimulus: rst low mid-BAKE between clock edges.
  - Required: all outputs 0 immediately; after release, stays IDLE until start.
